// File: rtl/fpga_exp2_fhr_pkg.sv
// Shared constants and types for the registered 1-to-8 data demultiplexer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Consumers import this with import fpga_exp2_pkg::*.
package fpga_exp2_pkg;

  localparam int NUM_OUT    = 8;
  localparam int SEL_W      = 3;
  localparam int DEF_DATA_W = 4;

  typedef logic [NUM_OUT-1:0] sel_t;

endpackage

// File: rtl/fpga_exp2_fhr_if.sv
// Source-side select/data and consumer-side one-hot/data buses of the demux.
// Latency: n/a (wiring only). Backpressure: none; consumers always accept.
// The master modport is the data source; the slave modport is the demux.
interface fpga_exp2_fhr_if
  import fpga_exp2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              en;
  logic [DATA_W-1:0] data4;
  logic [SEL_W-1:0]  cs;
  sel_t              csout;
  logic [DATA_W-1:0] dout0;
  logic [DATA_W-1:0] dout1;
  logic [DATA_W-1:0] dout2;
  logic [DATA_W-1:0] dout3;
  logic [DATA_W-1:0] dout4;
  logic [DATA_W-1:0] dout5;
  logic [DATA_W-1:0] dout6;
  logic [DATA_W-1:0] dout7;

  modport master (
    output en, data4, cs,
    input  csout, dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7
  );

  modport slave (
    input  en, data4, cs,
    output csout, dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7
  );

endinterface

// File: rtl/fpga_exp2_fhr_dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable.
// Latency: 0 cycles. Backpressure: none.
// en low forces an all-zero select.
module fhr_dec3to8
  import fpga_exp2_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] cs,
  output sel_t             sel
);

  always_comb begin
    sel = '0;
    if (en) begin
      sel[cs] = 1'b1;
    end
  end

endmodule

// File: rtl/fpga_exp2_fhr.sv
// Registered 1-to-8 demux: routes data4 to the port chosen by cs, one-hot csout.
// Latency: 1 cycle, fully registered. Backpressure: none; every cycle is accepted.
// FPGA_EXP2_FHR_HOLD_EN: unselected ports hold their value instead of clearing.
module fpga_exp2_fhr
  import fpga_exp2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  fpga_exp2_fhr_if.slave bus
);

  sel_t              sel;
  sel_t              csout_q;
  logic [DATA_W-1:0] dout_q [NUM_OUT];

  // One decode drives both the csout register and the per-port write enables.
  fhr_dec3to8 u_dec (
    .en  (bus.en),
    .cs  (bus.cs),
    .sel (sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csout_q <= '0;
    end else begin
      csout_q <= sel;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_port
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q[g] <= '0;
      end else begin
`ifdef FPGA_EXP2_FHR_HOLD_EN
        if (sel[g]) begin
          dout_q[g] <= bus.data4;
        end
`else
        dout_q[g] <= sel[g] ? bus.data4 : '0;
`endif
      end
    end
  end

  assign bus.csout = csout_q;
  assign bus.dout0 = dout_q[0];
  assign bus.dout1 = dout_q[1];
  assign bus.dout2 = dout_q[2];
  assign bus.dout3 = dout_q[3];
  assign bus.dout4 = dout_q[4];
  assign bus.dout5 = dout_q[5];
  assign bus.dout6 = dout_q[6];
  assign bus.dout7 = dout_q[7];

endmodule

// File: tb/tb_fpga_exp2_fhr.sv
// Directed and randomized checks of fpga_exp2_fhr against a port-level model.
module tb_fpga_exp2_fhr;

`ifdef FPGA_EXP2_FHR_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fpga_exp2_fhr_if #(.DATA_W(4)) bus ();

  fpga_exp2_fhr #(.DATA_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] obs [8];
  assign obs[0] = bus.dout0;
  assign obs[1] = bus.dout1;
  assign obs[2] = bus.dout2;
  assign obs[3] = bus.dout3;
  assign obs[4] = bus.dout4;
  assign obs[5] = bus.dout5;
  assign obs[6] = bus.dout6;
  assign obs[7] = bus.dout7;

  // Model: what each consumer port and the active-port indicator should show.
  logic [7:0] m_csout;
  logic [3:0] m_dout [8];

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
    total++;
    assert (o === e) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_all(input string what);
    check({what, " csout"}, bus.csout, m_csout);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("%s dout%0d", what, n), {4'h0, obs[n]}, {4'h0, m_dout[n]});
    end
  endtask

  task automatic model_reset();
    m_csout = 8'h00;
    for (int n = 0; n < 8; n++) m_dout[n] = 4'h0;
  endtask

  // Drive one cycle of inputs, let one rising edge sample them, then compare.
  task automatic step(input string what, input logic e, input logic [2:0] c, input logic [3:0] d);
    @(negedge clk);
    bus.en    = e;
    bus.cs    = c;
    bus.data4 = d;
    @(posedge clk);
    m_csout = e ? (8'h01 << c) : 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (e && n == int'(c)) m_dout[n] = d;
      else if (!HOLD)        m_dout[n] = 4'h0;
    end
    #1;
    check_all(what);
  endtask

  initial begin
    bus.en    = 1'b0;
    bus.cs    = 3'd0;
    bus.data4 = 4'h0;
    model_reset();

    #2;
    check_all("por");

    @(negedge clk);
    rst_n = 1'b1;

    // Load non-zero state, then reset mid-cycle without any clock edge.
    step("preload", 1'b1, 3'd3, 4'hF);
    step("preload2", 1'b1, 3'd3, 4'hF);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 8; c++) step($sformatf("zeros cs%0d", c), 1'b1, 3'(c), 4'h0);

    for (int c = 0; c < 8; c++) begin
      step($sformatf("ones cs%0d", c), 1'b1, 3'(c), 4'hF);
      if (c == 4) step("ones cs4 hold", 1'b1, 3'd4, 4'hF);
    end

    step("en_off", 1'b0, 3'd5, 4'hA);
    step("en_off2", 1'b0, 3'd2, 4'h5);

    step("wr cs0", 1'b1, 3'd0, 4'h3);
    step("wr cs1", 1'b1, 3'd1, 4'h7);

    step("same cs2", 1'b1, 3'd2, 4'h1);
    step("same cs6", 1'b1, 3'd6, 4'h9);

    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end

    // Reset clears everything even after random traffic.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("final_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
